// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch-direction predictor: 2-bit counter
// encodings, reset value and the saturating update function.
package branch_predict_resolve_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

  // Saturating step toward the resolved direction.
  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
    return nxt;
  endfunction

  function automatic logic ctr_taken(input ctr_e cur);
    return cur[1];
  endfunction

endpackage

// File: rtl/branch_predict_resolve_fifo.sv
// In-flight prediction FIFO: synchronous push/pop with a flush that
// empties the queue and drops any push in the same cycle.
module bp_inflight_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign push_ok = push & ~full_c & ~flush;
  assign pop_ok  = pop & ~empty_c;
  assign rdata_c = mem[rd_ptr];

  // Payload storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch-direction predictor: PC-indexed 2-bit counter table, in-order
// resolution against queued predictions, squash of younger entries on a miss.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pred_valid,
  input  logic [31:0]            pred_pc,
  output logic                   prediction,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   outcome,
  output logic                   miss,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned EW      = INDEX_BITS + 1;

  ctr_e                  ctr_q [ENTRIES];
  logic [INDEX_BITS-1:0] pred_idx;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_pred;
  logic [EW-1:0]         head_c;
  logic                  full_c;
  logic                  empty_c;
  logic                  push_c;
  logic                  res_accept_c;
  logic                  mispredict_c;
  logic                  unused_pc_bits;

  assign pred_idx       = pred_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};

  // Table read has no bypass: a same-cycle update is visible next cycle.
  assign prediction   = ctr_taken(ctr_q[pred_idx]);
  assign pred_ready   = ~full_c;
  assign push_c       = pred_valid & pred_ready;
  assign res_accept_c = res_valid & ~empty_c;
  assign {head_idx, head_pred} = head_c;
  assign mispredict_c = res_accept_c & (res_taken != head_pred);

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (res_accept_c),
    .flush   (mispredict_c),
    .wdata   ({pred_idx, prediction}),
    .rdata_c (head_c),
    .count   (count),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Train the counter named by the oldest in-flight prediction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_RESET;
    end else if (res_accept_c) begin
      ctr_q[head_idx] <= ctr_next(ctr_q[head_idx], res_taken);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss    <= 1'b0;
      outcome <= 1'b0;
    end else begin
      miss <= mispredict_c;
      if (res_accept_c) outcome <= res_taken;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench for branch_predict_resolve: directed vector table,
// mid-stream reset sequence, and random traffic against a queue-based model.
module tb_branch_predict_resolve;

  localparam int unsigned INDEX_BITS = 4;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned CW         = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRIES    = 1 << INDEX_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          pred_valid;
  logic [31:0]   pred_pc;
  logic          prediction;
  logic          pred_ready;
  logic          res_valid;
  logic          res_taken;
  logic          outcome;
  logic          miss;
  logic [CW-1:0] count;

  branch_predict_resolve #(.INDEX_BITS(INDEX_BITS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pred_valid (pred_valid),
    .pred_pc    (pred_pc),
    .prediction (prediction),
    .pred_ready (pred_ready),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .outcome    (outcome),
    .miss       (miss),
    .count      (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: counters as integers 0..3, in-flight queue of {index, guess}.
  typedef struct { int idx; bit pred; } ent_t;
  int   m_ctr [ENTRIES];
  ent_t m_q [$];
  bit   m_miss;
  bit   m_out;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) m_ctr[i] = 1;
    m_q.delete();
    m_miss = 0;
    m_out  = 0;
  endtask

  function automatic bit m_pred(input logic [31:0] pc);
    return m_ctr[idx_of(pc)] >= 2;
  endfunction

  task automatic model_clock(input bit pv, input logic [31:0] pc, input bit rv, input bit rt);
    bit   ready;
    bit   guess;
    ent_t e;
    ready  = m_q.size() < DEPTH;
    guess  = m_pred(pc);
    m_miss = 0;
    if (rv && m_q.size() > 0) begin
      e      = m_q.pop_front();
      m_out  = rt;
      m_miss = (rt != e.pred);
      if (rt) m_ctr[e.idx] = (m_ctr[e.idx] == 3) ? 3 : m_ctr[e.idx] + 1;
      else    m_ctr[e.idx] = (m_ctr[e.idx] == 0) ? 0 : m_ctr[e.idx] - 1;
      if (m_miss) m_q.delete();
    end
    if (pv && ready && !m_miss) m_q.push_back('{idx: idx_of(pc), pred: guess});
  endtask

  task automatic drive(input bit pv, input logic [31:0] pc, input bit rv, input bit rt);
    pred_valid = pv;
    pred_pc    = pc;
    res_valid  = rv;
    res_taken  = rt;
  endtask

  typedef struct {
    bit          pv;
    logic [31:0] pc;
    bit          rv;
    bit          rt;
    bit          e_pred;
    bit          e_ready;
    bit          e_miss;
    bit          e_out;
    int          e_count;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input bit pv, input logic [31:0] pc, input bit rv, input bit rt,
                              input bit ep, input bit er, input bit em, input bit eo, input int ec);
    vec_t v;
    v.pv = pv; v.pc = pc; v.rv = rv; v.rt = rt;
    v.e_pred = ep; v.e_ready = er; v.e_miss = em; v.e_out = eo; v.e_count = ec;
    return v;
  endfunction

  initial begin
    // idx 0 <- PC 0x100, idx 5 <- PC 0x114
    //                pv  pc     rv rt  pred rdy miss out cnt
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 1, 0, 0, 1));   // predict from reset WNT
    vecs.push_back(mk(0, 32'h100, 1, 1, 0, 1, 1, 1, 0));   // taken vs NT guess -> miss, ctr0=WT
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 1, 1));   // now predicts taken
    vecs.push_back(mk(0, 32'h100, 1, 1, 1, 1, 0, 1, 0));   // ctr0=ST
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 32'h100, 1, 1, 1, 1, 0, 1, 0));   // saturates at ST, no miss
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 1, 2));
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 1, 3));
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 1, 0, 1, 4));   // full
    vecs.push_back(mk(1, 32'h100, 0, 0, 1, 0, 0, 1, 4));   // push refused
    vecs.push_back(mk(1, 32'h100, 1, 1, 1, 0, 0, 1, 3));   // pop while full, push still refused
    vecs.push_back(mk(1, 32'h114, 1, 0, 0, 1, 1, 0, 0));   // head miss: flush, push dropped, ctr0=WT
    vecs.push_back(mk(0, 32'h114, 0, 0, 0, 1, 0, 0, 0));   // idx5 untouched
    vecs.push_back(mk(0, 32'h100, 0, 0, 1, 1, 0, 0, 0));   // idx0 at WT
    vecs.push_back(mk(0, 32'h100, 1, 1, 1, 1, 0, 0, 0));   // resolve on empty: outcome holds 0
    vecs.push_back(mk(0, 32'h100, 1, 0, 1, 1, 0, 0, 0));   // resolve on empty: no decrement
    vecs.push_back(mk(0, 32'h100, 0, 0, 1, 1, 0, 0, 0));   // idx0 still WT
    vecs.push_back(mk(1, 32'h114, 0, 0, 0, 1, 0, 0, 1));   // queue idx5 guess NT
    vecs.push_back(mk(1, 32'h114, 1, 1, 0, 1, 1, 1, 0));   // same-cycle update: old value read
    vecs.push_back(mk(0, 32'h114, 0, 0, 1, 1, 0, 1, 0));   // new value visible
  end

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_miss", 32'(miss), 32'd0);
    check("reset_outcome", 32'(outcome), 32'd0);
    check("reset_ready", 32'(pred_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pv, vecs[i].pc, vecs[i].rv, vecs[i].rt);
      @(negedge clk);
      check($sformatf("vec%0d_prediction", i), 32'(prediction), 32'(vecs[i].e_pred));
      check($sformatf("vec%0d_ready", i), 32'(pred_ready), 32'(vecs[i].e_ready));
      model_clock(vecs[i].pv, vecs[i].pc, vecs[i].rv, vecs[i].rt);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_miss", i), 32'(miss), 32'(vecs[i].e_miss));
      check($sformatf("vec%0d_outcome", i), 32'(outcome), 32'(vecs[i].e_out));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
    end

    // Mid-stream asynchronous reset with two branches in flight
    for (int i = 0; i < 2; i++) begin
      drive(1, (i == 0) ? 32'h100 : 32'h114, 0, 0);
      @(negedge clk);
      model_clock(1, pred_pc, 0, 0);
      @(posedge clk);
      #1;
    end
    drive(0, 32'h0, 0, 0);
    check("pre_reset_count", 32'(count), 32'd2);
    check("pre_reset_outcome", 32'(outcome), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_count", 32'(count), 32'd0);
    check("async_reset_miss", 32'(miss), 32'd0);
    check("async_reset_outcome", 32'(outcome), 32'd0);
    check("async_reset_ready", 32'(pred_ready), 32'd1);
    for (int i = 0; i < int'(ENTRIES); i++) begin
      pred_pc = 32'(i) << 2;
      #0.1;
      check($sformatf("async_reset_pred_idx%0d", i), 32'(prediction), 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit          pv;
      bit          rv;
      bit          rt;
      logic [31:0] pc;
      pv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 5);
      rt = $urandom_range(0, 1) == 1;
      pc = $urandom();
      drive(pv, pc, rv, rt);
      @(negedge clk);
      check("rand_prediction", 32'(prediction), 32'(m_pred(pc)));
      check("rand_ready", 32'(pred_ready), 32'(m_q.size() < DEPTH));
      model_clock(pv, pc, rv, rt);
      @(posedge clk);
      #1;
      check("rand_miss", 32'(miss), 32'(m_miss));
      check("rand_outcome", 32'(outcome), 32'(m_out));
      check("rand_count", 32'(count), 32'(m_q.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
